fifo_wr_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares the single write port of a synchronous FIFO between N_REQ producers.
- Each producer has a valid/ready/last handshake. The arbiter drives the FIFO write strobe and data through one register stage.
- It paces itself from the FIFO's full and almost-full flags so that no write is ever issued into a full FIFO.
- Sits directly in front of the team's sync FIFO, one instance per shared queue.

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet-locking arbiter for a shared FIFO write port
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0]            req_last_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        fifo_full_i,
    input  logic                        fifo_almost_full_i,
    output logic                        fifo_wr_valid_o,
    output logic [DATA_WIDTH-1:0]       fifo_data_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic [ID_WIDTH-1:0]         grant_id_o,
    output logic                        locked_o
);
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   rr_ptr_next;
    logic [ID_WIDTH-1:0]   owner;
    logic [ID_WIDTH-1:0]   owner_next;
    logic [ID_WIDTH-1:0]   id_hold;
    logic                  can_issue;
    logic                  rr_found;
    logic [ID_WIDTH-1:0]   rr_id;
    logic                  sel_found;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ID_WIDTH-1:0]   sel_id_inc;
    logic                  accept;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // The output register may already hold a write; with the FIFO one slot from
    // full that write will fill it, so nothing new may be issued this cycle.
    assign can_issue = !fifo_full_i && !(fifo_wr_valid_o && fifo_almost_full_i);

    // Rotating-priority search starting at rr_ptr; wrap uses a compare so any N_REQ works
    always_comb begin
        int cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_id    = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_id    = ID_WIDTH'(cand);
            end
        end
    end

    // A locked packet owner keeps the grant even while its valid is low
    always_comb begin
        sel_found = rr_found;
        sel_id    = rr_id;
        if (state == LOCKED) begin
            sel_found = 1'b1;
            sel_id    = owner;
        end
    end

    // One-hot grant and the single ready bit; both are masked while in reset
    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        if (!rst && sel_found) begin
            grant_o[sel_id]     = 1'b1;
            req_ready_o[sel_id] = req_valid_i[sel_id] & can_issue;
        end
    end

    assign grant_id_o = (!rst && sel_found) ? sel_id : id_hold;
    assign accept     = |req_ready_o;
    assign sel_last   = req_last_i[sel_id];
    assign sel_data   = req_data_i[sel_id*DATA_WIDTH +: DATA_WIDTH];
    assign sel_id_inc = (sel_id == ID_WIDTH'(N_REQ - 1)) ? '0 : sel_id + ID_WIDTH'(1);
    assign locked_o   = (state == LOCKED);

    // Packet lock FSM: a non-last beat locks the grantee, a last beat releases and rotates
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner;
        if (accept) begin
            if (sel_last) begin
                state_next  = IDLE;
                rr_ptr_next = sel_id_inc;
            end else begin
                state_next = LOCKED;
                owner_next = sel_id;
            end
        end
    end

    // Arbitration state; reset drops any lock without cleaning up the partial packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            id_hold <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            owner   <= owner_next;
            id_hold <= grant_id_o;
        end
    end

    // Single register stage towards the FIFO; data holds when no beat is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_valid_o <= 1'b0;
            fifo_data_o     <= '0;
        end else begin
            fifo_wr_valid_o <= accept;
            if (accept) begin
                fifo_data_o <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SLOTS = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_af;
    logic          fifo_wr_valid;
    logic [DW-1:0] fifo_data;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          locked;

    int            fifo_count = 0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] src_data [N][SLOTS];
    logic          src_last [N][SLOTS];
    int            src_len  [N];
    int            src_pos  [N];
    logic [N-1:0]  src_hold;
    logic [N-1:0]  acc;

    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] sb_exp;
    int            total = 0;
    int            bad = 0;
    int            wr_count = 0;
    int            full_writes = 0;
    int            w0;
    int            p0;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid),
        .req_last_i         (req_last),
        .req_data_i         (req_data),
        .req_ready_o        (req_ready),
        .fifo_full_i        (fifo_full),
        .fifo_almost_full_i (fifo_af),
        .fifo_wr_valid_o    (fifo_wr_valid),
        .fifo_data_o        (fifo_data),
        .grant_o            (grant),
        .grant_id_o         (grant_id),
        .locked_o           (locked)
    );

    always #5 clk = ~clk;

    assign fifo_full = (fifo_count >= DEPTH);
    assign fifo_af   = (fifo_count == DEPTH - 1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Sync FIFO model: depth 4, write from the arbiter strobe, read when rd_en
    always @(posedge clk) begin
        fifo_count <= fifo_count + (fifo_wr_valid ? 1 : 0) - ((rd_en && fifo_count > 0) ? 1 : 0);
    end

    // Scoreboard: every write strobe pops the next predicted beat
    always @(negedge clk) begin
        if (fifo_wr_valid === 1'b1) begin
            wr_count++;
            if (fifo_full) begin
                full_writes++;
            end
            check("sb_pending", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                check("fifo_data", 32'(fifo_data), 32'(sb_exp));
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_pos[k] < src_len[k]) begin
                req_valid[k]         = !src_hold[k];
                req_data[k*DW +: DW] = src_data[k][src_pos[k]];
                req_last[k]          = src_last[k][src_pos[k]];
            end else begin
                req_valid[k]         = 1'b0;
                req_data[k*DW +: DW] = '0;
                req_last[k]          = 1'b0;
            end
        end
    endtask

    task automatic apply();
        drive();
        #1;
        acc = req_ready & req_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                src_pos[k]++;
            end
        end
        drive();
        @(negedge clk);
        #1;
        acc = req_ready & req_valid;
    endtask

    task automatic load(input int k, input logic [DW-1:0] d, input logic l, input logic predict);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = l;
        src_len[k]++;
        if (predict) begin
            sb_q.push_back(d);
        end
    endtask

    initial begin
        src_hold = '0;
        acc      = '0;
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive();

        // reset: handshakes forced low even with every requester valid
        repeat (3) @(posedge clk);
        req_valid = '1;
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_grant", 32'(grant), 0);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            check("idle_wr_valid", 32'(fifo_wr_valid), 0);
            check("idle_grant", 32'(grant), 0);
            check("idle_locked", 32'(locked), 0);
            check("idle_ready", 32'(req_ready), 0);
            check("idle_grant_id", 32'(grant_id), 0);
            tick();
        end

        // round-robin fairness over single-beat packets
        rd_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++) begin
                load(k, 8'(8'hA0 + k), 1'b1, 1'b1);
            end
        end
        apply();
        check("rr_first_ready", 32'(req_ready), 'b0001);
        check("rr_first_wr_valid", 32'(fifo_wr_valid), 0);
        w0 = wr_count;
        tick();
        check("rr_first_strobe", 32'(fifo_wr_valid), 1);
        check("rr_first_data", 32'(fifo_data), 'hA0);
        check("rr_second_grant", 32'(grant), 'b0010);
        repeat (31) tick();
        check("rr_back_to_back_writes", 32'(wr_count - w0), 32);
        repeat (2) tick();
        check("rr_drained", 32'(sb_q.size()), 0);
        check("rr_wr_idle", 32'(fifo_wr_valid), 0);

        // packet lock with a valid gap while another requester waits
        load(1, 8'h11, 1'b0, 1'b1);
        load(1, 8'h12, 1'b0, 1'b1);
        load(1, 8'h13, 1'b1, 1'b1);
        load(2, 8'h21, 1'b1, 1'b1);
        apply();
        check("lock_first_grant", 32'(grant), 'b0010);
        check("lock_not_yet", 32'(locked), 0);
        tick();
        src_hold[1] = 1'b1;
        apply();
        check("lock_locked", 32'(locked), 1);
        check("lock_gap_ready", 32'(req_ready), 0);
        check("lock_gap_grant", 32'(grant), 'b0010);
        check("lock_gap_grant_id", 32'(grant_id), 1);
        tick();
        check("lock_gap2_ready", 32'(req_ready), 0);
        check("lock_gap2_locked", 32'(locked), 1);
        src_hold[1] = 1'b0;
        apply();
        check("lock_resume_ready", 32'(req_ready), 'b0010);
        tick();
        check("lock_last_locked", 32'(locked), 1);
        tick();
        check("lock_released", 32'(locked), 0);
        check("lock_next_grant", 32'(grant), 'b0100);
        check("lock_next_grant_id", 32'(grant_id), 2);
        repeat (4) tick();
        check("lock_drained", 32'(sb_q.size()), 0);

        // backpressure and almost-full guard, FIFO never read
        rd_en = 1'b0;
        p0 = src_pos[0];
        w0 = wr_count;
        for (int i = 0; i < 6; i++) begin
            load(0, 8'(8'h30 + i), 1'b1, 1'b1);
        end
        apply();
        repeat (4) tick();
        check("af_guard_inflight", 32'(fifo_wr_valid), 1);
        check("af_guard_ready", 32'(req_ready), 0);
        repeat (8) tick();
        check("bp_writes", 32'(wr_count - w0), 4);
        check("bp_accepts", 32'(src_pos[0] - p0), 4);
        check("bp_ready_low", 32'(req_ready), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        apply();
        repeat (8) tick();
        check("bp_one_more_write", 32'(wr_count - w0), 5);
        check("bp_one_more_accept", 32'(src_pos[0] - p0), 5);
        check("bp_pending", 32'(sb_q.size()), 1);
        rd_en = 1'b1;
        repeat (10) tick();
        check("bp_drained", 32'(sb_q.size()), 0);
        check("bp_all_accepted", 32'(src_pos[0] - p0), 6);

        // reset in the middle of a locked req3 packet
        p0 = src_pos[3];
        load(3, 8'h41, 1'b0, 1'b1);
        load(3, 8'h42, 1'b0, 1'b1);
        load(3, 8'h43, 1'b0, 1'b0);
        load(3, 8'h44, 1'b1, 1'b0);
        apply();
        check("mid_first_grant", 32'(grant), 'b1000);
        tick();
        check("mid_locked", 32'(locked), 1);
        tick();
        load(0, 8'h01, 1'b1, 1'b1);
        sb_q.push_back(8'h43);
        sb_q.push_back(8'h44);
        rst = 1'b1;
        apply();
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_grant", 32'(grant), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        #1;
        acc = req_ready & req_valid;
        check("post_rst_locked", 32'(locked), 0);
        check("post_rst_wr_valid", 32'(fifo_wr_valid), 0);
        check("post_rst_grant", 32'(grant), 'b0001);
        check("post_rst_grant_id", 32'(grant_id), 0);
        check("post_rst_ready", 32'(req_ready), 'b0001);
        repeat (8) tick();
        check("post_rst_drained", 32'(sb_q.size()), 0);
        check("post_rst_req3_done", 32'(src_pos[3] - p0), 4);

        check("no_write_into_full", 32'(full_writes), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
